// File: rtl/counter_ctrl_if.sv
// Handshake bundle between counter_ctrl and its environment.
// master: drives run requests and the counter value; slave: the controller.
interface counter_ctrl_if;
    logic       start;
    logic       abort;
    logic [3:0] limit;
    logic [7:0] periods;
    logic [3:0] count;
    logic       clear;
    logic       busy;
    logic       tick;
    logic       done;
    logic [7:0] period_cnt;

    modport master (
        output start,
        output abort,
        output limit,
        output periods,
        output count,
        input  clear,
        input  busy,
        input  tick,
        input  done,
        input  period_cnt
    );

    modport slave (
        input  start,
        input  abort,
        input  limit,
        input  periods,
        input  count,
        output clear,
        output busy,
        output tick,
        output done,
        output period_cnt
    );
endinterface

// File: rtl/counter_ctrl.sv
// Run controller for a downstream 4-bit free-running counter.
// Ports: clk, reset (async, active-low), ctl (counter_ctrl_if.slave):
//   start/abort/limit/periods/count in; clear/busy/tick/done/period_cnt out.
module counter_ctrl (
    input  logic           clk,
    input  logic           reset,
    counter_ctrl_if.slave  ctl
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_limit;
    logic [7:0] r_periods;
    logic [7:0] r_period_cnt;

    logic       w_hit;
    logic       w_accept;
    logic       w_last;
    logic       w_clear;
    logic       w_busy;
    logic       w_tick;
    logic       w_done;

    // Period ends when the counter reaches the captured limit.
    assign w_hit    = (ctl.count == r_limit);
    assign w_accept = (r_state == S_IDLE) && ctl.start && !ctl.abort;
    // Only a nonzero period budget can finish a run.
    assign w_last   = (r_periods != 8'd0) &&
                      ((r_period_cnt + 8'd1) == r_periods);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                // Abort wins over completion, so no done pulse.
                if (ctl.abort) begin
                    w_next = S_IDLE;
                end else if (w_hit && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_clear = 1'b1;
        w_busy  = 1'b0;
        w_tick  = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_clear = 1'b1;
            end
            S_RUN: begin
                w_busy  = 1'b1;
                w_tick  = w_hit;
                w_clear = w_hit;
            end
            S_DONE: begin
                w_done  = 1'b1;
            end
            default: begin
                w_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_limit      <= 4'd0;
            r_periods    <= 8'd0;
            r_period_cnt <= 8'd0;
        end else if (w_accept) begin
            r_limit      <= ctl.limit;
            r_periods    <= ctl.periods;
            r_period_cnt <= 8'd0;
        end else if (w_tick) begin
            // Wraps 255->0 in free-running mode.
            r_period_cnt <= r_period_cnt + 8'd1;
        end
    end

    assign ctl.clear      = w_clear;
    assign ctl.busy       = w_busy;
    assign ctl.tick       = w_tick;
    assign ctl.done       = w_done;
    assign ctl.period_cnt = r_period_cnt;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with a model of the downstream counter.
// Expected values are hand-derived per scenario.
module tb_counter_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] r_cnt = 4'd0;
    int n_cmp = 0;
    int n_err = 0;

    counter_ctrl_if bus ();

    counter_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus.slave)
    );

    always #5 clk = ~clk;

    // Downstream counter: clears on clear, otherwise increments.
    always @(posedge clk) begin
        if (bus.clear) r_cnt <= 4'd0;
        else           r_cnt <= r_cnt + 4'd1;
    end
    assign bus.count = r_cnt;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e_cnt;
        int e_tick;
        int e_done;
        int n_tick;

        reset = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.limit = 4'd0;
        bus.periods = 8'd0;
        #3;
        chk("rst_clear", bus.clear, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tick", bus.tick, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pcnt", bus.period_cnt, 0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("idle_clear", bus.clear, 1);
        chk("idle_busy", bus.busy, 0);

        // limit=3, periods=2
        bus.limit = 4'd3;
        bus.periods = 8'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t1_busy", bus.busy, 1);
            chk("t1_count", bus.count, i % 4);
            chk("t1_tick", bus.tick, (i % 4 == 3) ? 1 : 0);
            chk("t1_done", bus.done, 0);
            step();
        end
        chk("t1_done_pulse", bus.done, 1);
        chk("t1_busy_done", bus.busy, 0);
        chk("t1_pcnt", bus.period_cnt, 2);
        step();
        chk("t1_done_off", bus.done, 0);
        chk("t1_idle_clear", bus.clear, 1);
        chk("t1_pcnt_hold", bus.period_cnt, 2);

        // limit=0, periods=4
        bus.limit = 4'd0;
        bus.periods = 8'd4;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_tick", bus.tick, 1);
            chk("t2_count", bus.count, 0);
            chk("t2_clear", bus.clear, 1);
            step();
        end
        chk("t2_done", bus.done, 1);
        chk("t2_pcnt", bus.period_cnt, 4);
        step();
        chk("t2_done_off", bus.done, 0);

        // limit=15, free-running for 300 periods, with
        // a mid-run limit change and a start while busy.
        bus.limit = 4'd15;
        bus.periods = 8'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        e_cnt = 0;
        e_tick = 0;
        e_done = 0;
        n_tick = 0;
        for (int i = 0; i < 4800; i++) begin
            if (i == 100) bus.limit = 4'd2;
            if (i == 200) begin
                bus.start = 1'b1;
                bus.periods = 8'd3;
            end
            if (i == 201) bus.start = 1'b0;
            if (bus.count != 4'(i % 16)) e_cnt++;
            if (bus.tick != ((i % 16) == 15)) e_tick++;
            if (bus.done) e_done++;
            if (bus.tick) n_tick++;
            step();
        end
        chk("t3_count_err", e_cnt, 0);
        chk("t3_tick_err", e_tick, 0);
        chk("t3_done_seen", e_done, 0);
        chk("t3_ticks", n_tick, 300);
        chk("t3_pcnt", bus.period_cnt, 44);
        chk("t3_busy", bus.busy, 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("t3_abort_busy", bus.busy, 0);
        chk("t3_abort_done", bus.done, 0);
        chk("t3_abort_pcnt", bus.period_cnt, 44);

        // limit=5, periods=1, abort on the final tick
        bus.limit = 4'd5;
        bus.periods = 8'd1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t4_count", bus.count, 5);
        chk("t4_tick", bus.tick, 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("t4_busy", bus.busy, 0);
        chk("t4_done", bus.done, 0);
        chk("t4_pcnt", bus.period_cnt, 1);
        step();
        chk("t4_done_late", bus.done, 0);

        // reset mid-run at count=7
        bus.limit = 4'd15;
        bus.periods = 8'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 23; i++) step();
        chk("t5_count", bus.count, 7);
        chk("t5_pcnt_pre", bus.period_cnt, 1);
        reset = 1'b0;
        #1;
        chk("t5_busy", bus.busy, 0);
        chk("t5_clear", bus.clear, 1);
        chk("t5_pcnt", bus.period_cnt, 0);
        chk("t5_done", bus.done, 0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("t5_idle_busy", bus.busy, 0);
        bus.limit = 4'd2;
        bus.periods = 8'd1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_run_count", bus.count, i);
            chk("t5_run_tick", bus.tick, (i == 2) ? 1 : 0);
            step();
        end
        chk("t5_run_done", bus.done, 1);
        chk("t5_run_pcnt", bus.period_cnt, 1);
        step();

        // start and abort together in IDLE
        bus.limit = 4'd7;
        bus.periods = 8'd3;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("t6_busy", bus.busy, 0);
        chk("t6_clear", bus.clear, 1);
        chk("t6_pcnt", bus.period_cnt, 1);
        step();
        chk("t6_busy2", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
